// File: rtl/run_length_expander.sv
// run_length_expander: expands (run, value, dc) symbols into 64-coefficient zigzag-order blocks.
// Define DEZIGZAG_EN to report raster positions on index_out via a zigzag ROM.
module run_length_expander #(
  parameter int COEFF_W = 12,
  parameter int RUN_W   = 5
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic [COEFF_W-1:0] value_in,
  input  logic [RUN_W-1:0]   run_in,
  input  logic               dc_in,
  input  logic               valid_in,
  output logic               ready_out,
  output logic [COEFF_W-1:0] coeff_out,
  output logic [5:0]         index_out,
  output logic               last_out,
  output logic               valid_out,
  input  logic               ready_in,
  output logic               error_out
);
  typedef enum logic [2:0] {EXPECT_DC, EXPECT_AC, ZEROS, VALUE, FILL} state_t;
  state_t state_q, state_d;
  logic [5:0] pos_q, pos_d, index_q, index_d;
  logic [RUN_W-1:0] zcnt_q, zcnt_d;
  logic [COEFF_W-1:0] val_q, val_d, coeff_q, coeff_d, emit_val;
  logic en_q, valid_q, valid_d, last_q, last_d, error_q, error_d;
  logic emit, slot_free, take, overrun, eob;
`ifdef DEZIGZAG_EN
  localparam logic [5:0] ZZ [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63};
`endif
  // en_q holds off acceptance until the first clock after reset release
  assign slot_free = !valid_q || ready_in;
  assign ready_out = en_q && slot_free && (state_q == EXPECT_DC || (state_q == EXPECT_AC && !dc_in));
  assign take      = valid_in && ready_out;
  assign overrun   = 32'(pos_q) + 32'(run_in) > 32'd63;
  assign eob       = run_in == '0 && value_in == '0;
  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    zcnt_d   = zcnt_q;
    val_d    = val_q;
    emit     = 1'b0;
    emit_val = '0;
    error_d  = 1'b0;
    case (state_q)
      EXPECT_DC: if (take) begin
        emit     = dc_in;
        emit_val = value_in;
        error_d  = !dc_in;
        state_d  = dc_in ? EXPECT_AC : EXPECT_DC;
      end
      EXPECT_AC: if (valid_in && dc_in) begin
        error_d = 1'b1;
        state_d = FILL;
      end else if (take) begin
        emit     = 1'b1;
        error_d  = overrun;
        emit_val = (overrun || run_in != '0) ? '0 : value_in;
        val_d    = value_in;
        zcnt_d   = run_in - RUN_W'(1);
        state_d  = (overrun || eob) ? FILL : run_in == '0 ? EXPECT_AC :
                   run_in == RUN_W'(1) ? VALUE : ZEROS;
      end
      ZEROS: if (slot_free) begin
        emit    = 1'b1;
        zcnt_d  = zcnt_q - RUN_W'(1);
        state_d = zcnt_q == RUN_W'(1) ? VALUE : ZEROS;
      end
      VALUE: if (slot_free) begin
        emit     = 1'b1;
        emit_val = val_q;
        state_d  = EXPECT_AC;
      end
      FILL: emit = slot_free;
      default: state_d = EXPECT_DC;
    endcase
    // the emission at position 63 closes the block whatever state produced it
    if (emit) begin
      pos_d = pos_q + 6'd1;
      if (pos_q == 6'd63) state_d = EXPECT_DC;
    end
    valid_d = slot_free ? emit : valid_q;
    coeff_d = emit ? emit_val : coeff_q;
    last_d  = emit ? pos_q == 6'd63 : last_q;
`ifdef DEZIGZAG_EN
    index_d = emit ? ZZ[pos_q] : index_q;
`else
    index_d = emit ? pos_q : index_q;
`endif
  end
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= EXPECT_DC;
      pos_q   <= '0;
      zcnt_q  <= '0;
      val_q   <= '0;
      coeff_q <= '0;
      index_q <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      zcnt_q  <= zcnt_d;
      val_q   <= val_d;
      coeff_q <= coeff_d;
      index_q <= index_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      error_q <= error_d;
      en_q    <= 1'b1;
    end
  end
  assign coeff_out = coeff_q;
  assign index_out = index_q;
  assign last_out  = last_q;
  assign valid_out = valid_q;
  assign error_out = error_q;
endmodule

// File: tb/tb_run_length_expander.sv
// tb_run_length_expander: directed checks of block expansion, stalls, error recovery and reset.
module tb_run_length_expander;
  logic clk_in = 1'b0, rst_n_in = 1'b0;
  logic [11:0] value_in = '0, coeff_out;
  logic [4:0] run_in = '0;
  logic dc_in = 1'b0, valid_in = 1'b0, ready_in, ready_out, last_out, valid_out, error_out;
  logic [5:0] index_out;
  logic stall_mode = 1'b0, phase = 1'b0, prev_stall = 1'b0;
  logic [19:0] prev_pack = '0;
  int n_chk = 0, n_fail = 0, n_err = 0;
  typedef struct {int c; int i; bit l;} beat_t;
  beat_t cap[$];
  int exp_c[64];
`ifdef DEZIGZAG_EN
  localparam int ZZ[64] = '{
    0, 1, 8, 16, 9, 2, 3, 10, 17, 24, 32, 25, 18, 11, 4, 5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13, 6, 7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63};
`endif

  assign ready_in = !stall_mode || phase;
  always #5 clk_in = ~clk_in;
  always begin
    @(posedge clk_in);
    #1 phase = ~phase;
  end

  run_length_expander #(.COEFF_W(12), .RUN_W(5)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .value_in(value_in), .run_in(run_in),
    .dc_in(dc_in), .valid_in(valid_in), .ready_out(ready_out), .coeff_out(coeff_out),
    .index_out(index_out), .last_out(last_out), .valid_out(valid_out),
    .ready_in(ready_in), .error_out(error_out));

  function automatic int exp_idx(input int p);
`ifdef DEZIGZAG_EN
    return ZZ[p];
`else
    return p;
`endif
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk_in) begin
    if (valid_out && ready_in) cap.push_back('{int'($signed(coeff_out)), int'(index_out), last_out});
    if (error_out) n_err++;
    if (stall_mode && prev_stall)
      chk("stall hold", int'({valid_out, coeff_out, index_out, last_out}), int'(prev_pack));
    prev_stall = valid_out && !ready_in;
    prev_pack  = {valid_out, coeff_out, index_out, last_out};
  end

  task automatic send(input bit dc, input int run, input int val);
    int t = 0;
    dc_in = dc; run_in = 5'(run); value_in = 12'(val); valid_in = 1'b1;
    do begin
      @(negedge clk_in);
      t++;
    end while (!ready_out && t < 300);
    chk("send accepted", int'(ready_out), 1);
    @(posedge clk_in);
    #1 valid_in = 1'b0; dc_in = 1'b0;
  endtask

  task automatic wait_beats(input int n);
    int t = 0;
    while (cap.size() < n && t < 400) begin
      @(negedge clk_in);
      t++;
    end
    repeat (4) @(negedge clk_in);
    chk("beat count", cap.size(), n);
    @(posedge clk_in);
    #1;
  endtask

  task automatic check_block(input string tag, input int base);
    if (cap.size() >= base + 64)
      for (int p = 0; p < 64; p++) begin
        chk($sformatf("%s coeff[%0d]", tag, p), cap[base+p].c, exp_c[p]);
        chk($sformatf("%s index[%0d]", tag, p), cap[base+p].i, exp_idx(p));
        chk($sformatf("%s last[%0d]", tag, p), int'(cap[base+p].l), int'(p == 63));
      end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int nl;
    valid_in = 1'b1; dc_in = 1'b1;
    repeat (3) @(negedge clk_in);
    chk("reset valid_out", int'(valid_out), 0);
    chk("reset ready_out", int'(ready_out), 0);
    chk("reset error_out", int'(error_out), 0);
    chk("reset coeff_out", int'(coeff_out), 0);
    chk("reset index_out", int'(index_out), 0);
    chk("reset last_out", int'(last_out), 0);
    valid_in = 1'b0; dc_in = 1'b0;
    @(posedge clk_in);
    #1 rst_n_in = 1'b1;

    cap.delete(); n_err = 0; exp_c = '{default: 0};
    exp_c[0] = 5; exp_c[3] = -3;
    send(1, 0, 5); send(0, 2, -3); send(0, 0, 0);
    wait_beats(64);
    check_block("t1", 0);
    chk("t1 errors", n_err, 0);

    cap.delete(); n_err = 0;
    stall_mode = 1'b1;
    send(1, 0, 5); send(0, 2, -3); send(0, 0, 0);
    wait_beats(64);
    stall_mode = 1'b0;
    check_block("t1 stall", 0);
    chk("t1 stall errors", n_err, 0);

    cap.delete(); n_err = 0; exp_c = '{default: 0};
    exp_c[0] = 1; exp_c[63] = 7;
    send(1, 0, 1);
    repeat (3) send(0, 15, 0);
    send(0, 14, 7);
    wait_beats(64);
    check_block("t2", 0);
    chk("t2 errors", n_err, 0);

    cap.delete(); n_err = 0; exp_c = '{default: 0};
    exp_c[0] = 3; exp_c[49] = 8;
    send(1, 0, 3);
    repeat (3) send(0, 15, 0);
    send(0, 0, 8); send(0, 20, 4);
    wait_beats(64);
    check_block("t3 overrun", 0);
    chk("t3 errors", n_err, 1);

    cap.delete(); n_err = 0; exp_c = '{default: 0};
    exp_c[0] = 2; exp_c[1] = 1;
    send(1, 0, 2); send(0, 0, 1); send(1, 0, 9); send(0, 0, 0);
    wait_beats(128);
    check_block("t4 early dc", 0);
    exp_c = '{default: 0};
    exp_c[0] = 9;
    check_block("t4 next block", 64);
    chk("t4 errors", n_err, 1);

    cap.delete(); n_err = 0;
    send(1, 0, 4); send(0, 20, 5);
    repeat (2) @(posedge clk_in);
    #3 rst_n_in = 1'b0;
    #1;
    chk("t5 reset valid_out", int'(valid_out), 0);
    chk("t5 reset index_out", int'(index_out), 0);
    chk("t5 reset ready_out", int'(ready_out), 0);
    nl = 0;
    foreach (cap[k]) nl += int'(cap[k].l);
    chk("t5 partial no last", nl, 0);
    @(posedge clk_in);
    #1 rst_n_in = 1'b1;
    cap.delete(); n_err = 0; exp_c = '{default: 0};
    exp_c[0] = 6;
    send(1, 0, 6); send(0, 0, 0);
    wait_beats(64);
    check_block("t5 after reset", 0);
    chk("t5 errors", n_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
